// File: rtl/window_pkg.sv
// Shared types and widths for the 3x3 window controller.
package window_pkg;
  localparam int CNT_W  = 10;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/window_pos_cnt.sv
// Column/row position counter for the word stream; raster order, wraps to (0,0) after the last word.
module window_pos_cnt
  import window_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_last
);
  logic [CNT_W-1:0] r_col, r_row;
  logic             w_col_end, w_row_end;

  assign w_col_end = (r_col == CNT_W'(IMG_W - 1));
  assign w_row_end = (r_row == CNT_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        // the frame's last word rolls straight back to the origin for the next frame
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_end & w_row_end;
endmodule

// File: rtl/window_ctrl.sv
// Frame controller for a 3x3 word sliding window: gates upstream words into the shift chains
// and reports window centres. Define WINDOW_CTRL_FRAME_CNT_EN to add the frame_cnt output.
module window_ctrl
  import window_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              shift_en,
  output logic              window_valid,
  output logic [CNT_W-1:0]  win_col,
  output logic [CNT_W-1:0]  win_row,
  output logic              busy,
`ifdef WINDOW_CTRL_FRAME_CNT_EN
  output logic [FCNT_W-1:0] frame_cnt,
`endif
  output logic              done
);
  state_e           r_state, w_next;
  logic             w_in_ready, w_acc, w_win, w_last;
  logic [CNT_W-1:0] w_col, w_row;
  logic             r_wv;
  logic [CNT_W-1:0] r_wc, r_wr;

  // reset masks acceptance so no word is shifted in a reset cycle
  assign w_in_ready = (r_state == S_RUN) & out_ready & ~rst;
  assign w_acc      = in_valid & w_in_ready;
  assign w_win      = w_acc & (w_col >= CNT_W'(2)) & (w_row >= CNT_W'(2));

  window_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_acc),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_acc && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // the accepted word is the bottom-right of the window, so the centre is one up and one left
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wv <= 1'b0;
      r_wc <= '0;
      r_wr <= '0;
    end else begin
      r_wv <= w_win;
      if (w_win) begin
        r_wc <= w_col - 1'b1;
        r_wr <= w_row - 1'b1;
      end
    end
  end

`ifdef WINDOW_CTRL_FRAME_CNT_EN
  logic [FCNT_W-1:0] r_fcnt;
  always_ff @(posedge clk) begin
    if (rst)                                    r_fcnt <= '0;
    else if (r_state == S_RUN && w_next == S_DONE) r_fcnt <= r_fcnt + 1'b1;
  end
  assign frame_cnt = r_fcnt;
`endif

  assign in_ready     = w_in_ready;
  assign shift_en     = w_acc;
  assign window_valid = r_wv;
  assign win_col      = r_wc;
  assign win_row      = r_wr;
  assign busy         = (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
endmodule

// File: tb/tb_window_ctrl.sv
// Randomized scoreboard bench for window_ctrl: a word-count reference model predicts windows
// and handshakes; a separate monitor pops expected windows whenever window_valid is seen.
module tb_window_ctrl;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic       in_ready, shift_en, window_valid, busy, done;
  logic [9:0] win_col, win_row;
`ifdef WINDOW_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  int          m_fcnt = 0;
`endif

  window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .shift_en(shift_en), .window_valid(window_valid),
    .win_col(win_col), .win_row(win_row), .busy(busy),
`ifdef WINDOW_CTRL_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int r; } win_t;
  win_t q[$];

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int m_phase = 0;   // 0 idle, 1 in frame, 2 frame just finished
  int m_n = 0;       // words accepted in the current frame

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: predicts handshake outputs and the window each accepted word completes
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_ready, e_acc;
      e_ready = (m_phase == 1) && out_ready && !rst;
      e_acc   = e_ready && in_valid;
      chk("in_ready", int'(in_ready), int'(e_ready));
      chk("shift_en", int'(shift_en), int'(e_acc));
      chk("busy", int'(busy), int'(m_phase == 1));
      chk("done", int'(done), int'(m_phase == 2));
`ifdef WINDOW_CTRL_FRAME_CNT_EN
      chk("frame_cnt", int'(frame_cnt), m_fcnt);
`endif
      if (rst) begin
        m_phase = 0;
        m_n = 0;
`ifdef WINDOW_CTRL_FRAME_CNT_EN
        m_fcnt = 0;
`endif
      end else if (m_phase == 0) begin
        if (start) m_phase = 1;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (e_acc) begin
        int c, r;
        c = m_n % W;
        r = m_n / W;
        if (c >= 2 && r >= 2) q.push_back('{c - 1, r - 1});
        m_n++;
        if (m_n == W * H) begin
          m_n = 0;
          m_phase = 2;
`ifdef WINDOW_CTRL_FRAME_CNT_EN
          m_fcnt = (m_fcnt + 1) % 65536;
`endif
        end
      end
    end
  end

  // monitor: every presented window must be the oldest one the model predicted
  always @(negedge clk) begin
    if (chk_en && window_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        win_t e;
        e = q.pop_front();
        chk("win_col", int'(win_col), e.c);
        chk("win_row", int'(win_row), e.r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one frame with everything high, optional out_ready stall; returns start-to-done cycles
  task automatic frame(input int stall_at, input int stall_len, output int cyc);
    start = 1; in_valid = 1; out_ready = 1;
    step();
    start = 0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc == stall_at) out_ready = 0;
      if (cyc == stall_at + stall_len) out_ready = 1;
      // a start pulse mid-frame must change nothing
      if (cyc == 5) start = 1; else start = 0;
      step();
      cyc++;
    end
    start = 0;
  endtask

  initial begin
    int cyc, wins_before;
    rst = 1; start = 0; in_valid = 0; out_ready = 0;
    step(); step();
    rst = 0;
    chk("rst_window_valid", int'(window_valid), 0);
    chk("rst_win_col", int'(win_col), 0);
    chk("rst_win_row", int'(win_row), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_en = 1;

    // idle with in_valid high and no start: nothing may shift
    in_valid = 1; out_ready = 1;
    repeat (10) step();

    // uninterrupted frame: four windows, done after W*H accepts
    wins_before = n_chk;
    frame(-10, 0, cyc);
    chk("frame_cycles", cyc, W * H + 1);
    step();

    // three-cycle downstream stall in row 2
    frame(10, 3, cyc);
    chk("stall_frame_cycles", cyc, W * H + 1 + 3);
    step();

    // reset after seven accepts aborts the frame
    start = 1; in_valid = 1; out_ready = 1;
    step();
    start = 0;
    repeat (7) step();
    rst = 1;
    step();
    rst = 0;
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_window_valid", int'(window_valid), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (5) step();
    frame(-10, 0, cyc);
    chk("post_abort_frame_cycles", cyc, W * H + 1);
    step();

    // randomized handshakes, starts and rare resets
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; start = 0; in_valid = 0; out_ready = 0;
    step(); step();
    chk("windows_outstanding", q.size(), 0);
    if (n_chk - wins_before < 12) chk("too_few_checks", n_chk - wins_before, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
